// File: rtl/pc_delay_line_pkg.sv
// Shared definitions for the PC delay line: default PC width/reset value and
// the per-cycle operation decode that fixes the control priority in one place.
package pc_delay_line_pkg;

  localparam int          PC_WIDTH     = 32;
  localparam int unsigned PC_RESET_VAL = 0;

  typedef enum logic [2:0] {
    OP_CLEAR,
    OP_REDIRECT,
    OP_FLUSH,
    OP_STALL,
    OP_SHIFT
  } pipe_op_e;

  // Priority: !work_ena > redirect > flush > stall > shift.
  function automatic pipe_op_e decode_op(input logic work_ena,
                                         input logic redirect,
                                         input logic flush,
                                         input logic stall);
    if (!work_ena) return OP_CLEAR;
    if (redirect)  return OP_REDIRECT;
    if (flush)     return OP_FLUSH;
    if (stall)     return OP_STALL;
    return OP_SHIFT;
  endfunction

endpackage

// File: rtl/pc_stage_reg.sv
// One PC + valid register of the delay line. Clear beats load; hold blocks load.
module pc_stage_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            hold,
  input  logic [PC_W-1:0] pc_d,
  input  logic            vld_d,
  output logic [PC_W-1:0] pc_q,
  output logic            vld_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      vld_q <= 1'b0;
    end else if (clear) begin
      pc_q  <= RESET_PC;
      vld_q <= 1'b0;
    end else if (load && !hold) begin
      pc_q  <= pc_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/pc_delay_line.sv
// DEPTH-stage PC/valid delay line keeping the fetch PC aligned with its
// instruction, with flush, redirect into the output stage, taps and occupancy.
module pc_delay_line
  import pc_delay_line_pkg::*;
#(
  parameter int              PC_W     = PC_WIDTH,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(PC_RESET_VAL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       work_ena,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic [PC_W-1:0]            pc_i,
  input  logic                       pc_valid_i,
  output logic [PC_W-1:0]            pc_o,
  output logic                       pc_valid_o,
  output logic [DEPTH*PC_W-1:0]      stage_pc_o,
  output logic [DEPTH-1:0]           stage_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_depth_check
    $error("pc_delay_line: DEPTH must be at least 1");
  end

  pipe_op_e        op;
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [OCC_W-1:0] occ_q;

  assign op = decode_op(work_ena, redirect, flush, stall);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [PC_W-1:0] shift_pc;
    logic            shift_vld;
    logic [PC_W-1:0] d_pc;
    logic            d_vld;
    logic            clr;

    if (g == 0) begin : g_head
      assign shift_pc  = pc_i;
      assign shift_vld = pc_valid_i;
    end else begin : g_body
      assign shift_pc  = pc_q[g-1];
      assign shift_vld = vld_q[g-1];
    end

    // The output stage is where a redirect target lands; the rest are emptied.
    if (g == DEPTH - 1) begin : g_tail
      assign d_pc  = (op == OP_REDIRECT) ? redirect_pc : shift_pc;
      assign d_vld = (op == OP_REDIRECT) || shift_vld;
      assign clr   = (op == OP_CLEAR) || (op == OP_FLUSH);
    end else begin : g_mid
      assign d_pc  = shift_pc;
      assign d_vld = shift_vld;
      assign clr   = op inside {OP_CLEAR, OP_FLUSH, OP_REDIRECT};
    end

    pc_stage_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  ((op == OP_SHIFT) || (op == OP_REDIRECT)),
      .clear (clr),
      .hold  (op == OP_STALL),
      .pc_d  (d_pc),
      .vld_d (d_vld),
      .pc_q  (pc_q[g]),
      .vld_q (vld_q[g])
    );

    assign stage_pc_o[g*PC_W +: PC_W] = pc_q[g];
  end

  // Occupancy tracks the valid popcount incrementally rather than recounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      case (op)
        OP_CLEAR, OP_FLUSH: occ_q <= '0;
        OP_REDIRECT:        occ_q <= OCC_W'(1);
        OP_STALL:           occ_q <= occ_q;
        OP_SHIFT:           occ_q <= occ_q + OCC_W'(pc_valid_i) - OCC_W'(vld_q[DEPTH-1]);
        default:            occ_q <= occ_q;
      endcase
    end
  end

  assign pc_o          = pc_q[DEPTH-1];
  assign pc_valid_o    = vld_q[DEPTH-1];
  assign stage_valid_o = vld_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pc_delay_line.sv
// Directed bench for pc_delay_line: DEPTH=2/PC_W=32 hand-checked scenarios plus
// DEPTH=1/PC_W=16 and DEPTH=5/PC_W=32 instances checked against a shift model.
module tb_pc_delay_line;

  logic        clk = 1'b0;
  logic        rst, work_ena, stall, flush, redirect, pc_valid_i;
  logic [31:0] redirect_pc, pc_i;

  logic [15:0]  d1_pc_o;  logic d1_vo; logic [15:0]  d1_spc; logic [0:0] d1_sv; logic [0:0] d1_occ;
  logic [31:0]  d2_pc_o;  logic d2_vo; logic [63:0]  d2_spc; logic [1:0] d2_sv; logic [1:0] d2_occ;
  logic [31:0]  d5_pc_o;  logic d5_vo; logic [159:0] d5_spc; logic [4:0] d5_sv; logic [2:0] d5_occ;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int DEP [3] = '{1, 2, 5};
  logic [31:0] mp [3][5];
  logic        mv [3][5];

  always #5 clk = ~clk;

  pc_delay_line #(.PC_W(16), .DEPTH(1), .RESET_PC(16'h0)) u_d1 (
    .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc[15:0]), .pc_i(pc_i[15:0]),
    .pc_valid_i(pc_valid_i), .pc_o(d1_pc_o), .pc_valid_o(d1_vo),
    .stage_pc_o(d1_spc), .stage_valid_o(d1_sv), .occupancy(d1_occ));

  pc_delay_line #(.PC_W(32), .DEPTH(2), .RESET_PC(32'h0)) u_d2 (
    .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc_i(pc_i),
    .pc_valid_i(pc_valid_i), .pc_o(d2_pc_o), .pc_valid_o(d2_vo),
    .stage_pc_o(d2_spc), .stage_valid_o(d2_sv), .occupancy(d2_occ));

  pc_delay_line #(.PC_W(32), .DEPTH(5), .RESET_PC(32'h0)) u_d5 (
    .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc_i(pc_i),
    .pc_valid_i(pc_valid_i), .pc_o(d5_pc_o), .pc_valid_o(d5_vo),
    .stage_pc_o(d5_spc), .stage_valid_o(d5_sv), .occupancy(d5_occ));

  function automatic void model_reset();
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < 5; k++) begin
        mp[n][k] = 32'h0;
        mv[n][k] = 1'b0;
      end
  endfunction

  // Reference shift model for the three instances, evaluated with the inputs
  // present at the upcoming clock edge.
  function automatic void model_step();
    for (int n = 0; n < 3; n++) begin
      logic [31:0] mask;
      mask = (n == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (!work_ena || redirect || flush) begin
        for (int k = 0; k < DEP[n]; k++) begin
          mp[n][k] = 32'h0;
          mv[n][k] = 1'b0;
        end
        if (work_ena && redirect) begin
          mp[n][DEP[n]-1] = redirect_pc & mask;
          mv[n][DEP[n]-1] = 1'b1;
        end
      end else if (!stall) begin
        for (int k = DEP[n] - 1; k > 0; k--) begin
          mp[n][k] = mp[n][k-1];
          mv[n][k] = mv[n][k-1];
        end
        mp[n][0] = pc_i & mask;
        mv[n][0] = pc_valid_i;
      end
    end
  endfunction

  function automatic int mcount(int n);
    int c = 0;
    for (int k = 0; k < DEP[n]; k++) c += int'(mv[n][k]);
    return c;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic v);
    pc_i       = pc;
    pc_valid_i = v;
  endtask

  task automatic test_reset();
    n_chk++; if (d2_pc_o !== 32'h0 || d2_sv !== 2'b00) $display("FAIL rst_init_d2: pc_o=%h sv=%b expected 0/00", d2_pc_o, d2_sv); else n_pass++;
    n_chk++; if (d2_occ !== 2'd0 || d5_occ !== 3'd0 || d1_occ !== 1'd0) $display("FAIL rst_init_occ: d1=%0d d2=%0d d5=%0d expected 0", d1_occ, d2_occ, d5_occ); else n_pass++;
    rst = 1'b0;
    set_in(32'h100, 1'b1); tick();
    n_chk++; if (d2_occ !== 2'd1 || d2_vo !== 1'b0) $display("FAIL t1_c1: occ=%0d vo=%b expected 1/0", d2_occ, d2_vo); else n_pass++;
    set_in(32'h104, 1'b1); tick();
    n_chk++; if (d2_pc_o !== 32'h100 || d2_vo !== 1'b1 || d2_occ !== 2'd2) $display("FAIL t1_c2: pc_o=%h vo=%b occ=%0d expected 100/1/2", d2_pc_o, d2_vo, d2_occ); else n_pass++;
    set_in(32'h108, 1'b1); tick();
    n_chk++; if (d2_pc_o !== 32'h104 || d2_occ !== 2'd2) $display("FAIL t1_c3: pc_o=%h occ=%0d expected 104/2", d2_pc_o, d2_occ); else n_pass++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_chk++; if (d2_pc_o !== 32'h0 || d2_sv !== 2'b00 || d2_occ !== 2'd0) $display("FAIL t1_async_rst: pc_o=%h sv=%b occ=%0d expected 0/00/0", d2_pc_o, d2_sv, d2_occ); else n_pass++;
    n_chk++; if (d5_sv !== 5'b0 || d5_occ !== 3'd0) $display("FAIL t1_async_rst_d5: sv=%b occ=%0d expected 0/0", d5_sv, d5_occ); else n_pass++;
    #1 rst = 1'b0;
  endtask

  task automatic test_stall();
    set_in(32'h200, 1'b1); tick();
    set_in(32'h204, 1'b1); tick();
    n_chk++; if (d2_pc_o !== 32'h200 || d2_occ !== 2'd2) $display("FAIL t2_fill: pc_o=%h occ=%0d expected 200/2", d2_pc_o, d2_occ); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h300 + 32'(4 * i), 1'b1); tick();
      n_chk++; if (d2_pc_o !== 32'h200 || d2_occ !== 2'd2 || d2_spc[31:0] !== 32'h204) $display("FAIL t2_hold%0d: pc_o=%h occ=%0d s0=%h expected 200/2/204", i, d2_pc_o, d2_occ, d2_spc[31:0]); else n_pass++;
    end
    stall = 1'b0;
    set_in(32'h208, 1'b1); tick();
    n_chk++; if (d2_pc_o !== 32'h204 || d2_spc[31:0] !== 32'h208) $display("FAIL t2_release: pc_o=%h s0=%h expected 204/208", d2_pc_o, d2_spc[31:0]); else n_pass++;
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1; flush = 1'b1;
    set_in(32'h20C, 1'b1); tick();
    n_chk++; if (d2_pc_o !== 32'h400 || d2_vo !== 1'b1) $display("FAIL t3_pc: pc_o=%h vo=%b expected 400/1", d2_pc_o, d2_vo); else n_pass++;
    n_chk++; if (d2_sv !== 2'b10 || d2_occ !== 2'd1) $display("FAIL t3_valid: sv=%b occ=%0d expected 10/1", d2_sv, d2_occ); else n_pass++;
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_flush_work_ena();
    set_in(32'h500, 1'b1); tick();
    flush = 1'b1; tick();
    n_chk++; if (d2_sv !== 2'b00 || d2_occ !== 2'd0 || d2_spc !== 64'h0) $display("FAIL t4_flush: sv=%b occ=%0d spc=%h expected 00/0/0", d2_sv, d2_occ, d2_spc); else n_pass++;
    flush = 1'b0;
    set_in(32'h600, 1'b1); tick();
    set_in(32'h604, 1'b1); tick();
    n_chk++; if (d2_occ !== 2'd2 || d2_pc_o !== 32'h600) $display("FAIL t4_refill: occ=%0d pc_o=%h expected 2/600", d2_occ, d2_pc_o); else n_pass++;
    work_ena = 1'b0; redirect = 1'b1; redirect_pc = 32'h700; tick();
    n_chk++; if (d2_sv !== 2'b00 || d2_pc_o !== 32'h0 || d2_occ !== 2'd0) $display("FAIL t4_work_ena: sv=%b pc_o=%h occ=%0d expected 00/0/0", d2_sv, d2_pc_o, d2_occ); else n_pass++;
    work_ena = 1'b1; redirect = 1'b0;
  endtask

  task automatic test_bubbles();
    logic v_in   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_vo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_occ[6] = '{1, 1, 1, 1, 0, 0};
    for (int j = 0; j < 6; j++) begin
      logic [31:0] exp_pc;
      set_in(32'h800 + 32'(4 * j), v_in[j]); tick();
      exp_pc = (j == 0) ? 32'h0 : 32'h800 + 32'(4 * (j - 1));
      n_chk++; if (d2_vo !== exp_vo[j] || d2_occ !== 2'(exp_occ[j]) || d2_pc_o !== exp_pc) $display("FAIL t5_bubble%0d: vo=%b occ=%0d pc_o=%h expected %b/%0d/%h", j, d2_vo, d2_occ, d2_pc_o, exp_vo[j], exp_occ[j], exp_pc); else n_pass++;
    end
  endtask

  task automatic test_latency();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (t == 1) set_in(32'hA00, 1'b1); else set_in(32'h0, 1'b0);
      tick();
      n_chk++; if (d1_vo !== (t == 1) || d2_vo !== (t == 2) || d5_vo !== (t == 5)) $display("FAIL t6_latency%0d: d1=%b d2=%b d5=%b expected %b/%b/%b", t, d1_vo, d2_vo, d5_vo, t == 1, t == 2, t == 5); else n_pass++;
    end
    n_chk++; if (d5_occ !== 3'd0) $display("FAIL t6_latency_drain: d5 occ=%0d expected 0", d5_occ); else n_pass++;
  endtask

  task automatic test_sweep();
    // {work_ena, redirect, flush, stall, pc_valid_i} per cycle
    logic [4:0] seq [16] = '{5'b10001, 5'b10001, 5'b10000, 5'b10001, 5'b10011, 5'b10011,
                             5'b10001, 5'b11000, 5'b10001, 5'b10101, 5'b10001, 5'b10001,
                             5'b11111, 5'b00001, 5'b10001, 5'b10001};
    for (int i = 0; i < 16; i++) begin
      {work_ena, redirect, flush, stall, pc_valid_i} = seq[i];
      pc_i        = 32'hC_0C00 + 32'(4 * i);
      redirect_pc = 32'hE_0E00 + 32'(16 * i);
      tick();
      for (int n = 0; n < 3; n++)
        for (int k = 0; k < DEP[n]; k++) begin
          logic [31:0] got_pc;
          logic        got_v;
          if (n == 0)      begin got_pc = {16'h0, d1_spc}; got_v = d1_sv[0]; end
          else if (n == 1) begin got_pc = d2_spc[k*32 +: 32]; got_v = d2_sv[k]; end
          else             begin got_pc = d5_spc[k*32 +: 32]; got_v = d5_sv[k]; end
          n_chk++; if (got_pc !== mp[n][k] || got_v !== mv[n][k]) $display("FAIL sweep_tap c%0d d%0d s%0d: pc=%h v=%b expected %h/%b", i, DEP[n], k, got_pc, got_v, mp[n][k], mv[n][k]); else n_pass++;
        end
      n_chk++; if (int'(d1_occ) != mcount(0) || int'(d2_occ) != mcount(1) || int'(d5_occ) != mcount(2)) $display("FAIL sweep_occ c%0d: %0d/%0d/%0d expected %0d/%0d/%0d", i, d1_occ, d2_occ, d5_occ, mcount(0), mcount(1), mcount(2)); else n_pass++;
      n_chk++; if (d5_pc_o !== mp[2][4] || d5_vo !== mv[2][4] || d1_pc_o !== mp[0][0][15:0]) $display("FAIL sweep_out c%0d: d5=%h/%b d1=%h expected %h/%b/%h", i, d5_pc_o, d5_vo, d1_pc_o, mp[2][4], mv[2][4], mp[0][0][15:0]); else n_pass++;
    end
    work_ena = 1'b1; redirect = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; work_ena = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; pc_i = 32'h0; pc_valid_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_flush_work_ena();
    test_bubbles();
    test_latency();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_delay_line.md
Name: pc_delay_line

Overview:
- Parametrised PC-tracking pipeline. Delays the fetch PC by DEPTH clock cycles so that a PC stays paired with its instruction as it moves through BRAM and the later pipeline stages.
- Next generation of the single-register PC delay. Adds:
  - configurable depth;
  - a valid bit per stage;
  - flush and redirect;
  - stage taps;
  - an occupancy count.
- Sits between the PC generator and decode/execute. Consumers read the PC/valid pair at the output, or at any intermediate tap.

Parameters:
- PC_W, `PC_WIDTH, PC bit width.
- DEPTH, 2, number of delay stages. Must be ≥1; DEPTH=0 is an elaboration error, enforced with a generate-time check.
- RESET_PC, 0, value loaded into every stage PC on reset, on !work_ena and on flush.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- work_ena  in  1  core enable; 0 clears the pipeline synchronously
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- redirect  in  1  jump/branch taken; inject redirect_pc at the output stage
- redirect_pc  in  PC_W  target PC
- pc_i  in  PC_W  fetch PC
- pc_valid_i  in  1  pc_i is a real fetch (0 = bubble)
- pc_o  out  PC_W  stage DEPTH-1 PC
- pc_valid_o  out  1  stage DEPTH-1 valid
- stage_pc_o  out  DEPTH*PC_W  all stage PCs; stage k occupies bits [k*PC_W +: PC_W]
- stage_valid_o  out  DEPTH  all stage valid bits
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- All state is registered. Outputs come directly from registers; there is no combinational path from input to output.
- Async reset (rst=1): every stage PC = RESET_PC, every valid = 0, occupancy = 0. Takes effect immediately, independent of clk. Deassertion mid-stream restarts from the empty state.
- Per-cycle priority, highest first: rst > !work_ena > redirect > flush > stall > shift.
  - !work_ena: every stage PC = RESET_PC, every valid = 0, occupancy = 0.
  - redirect:
    - stage DEPTH-1 = {redirect_pc, valid=1};
    - stages 0..DEPTH-2 = {RESET_PC, 0};
    - occupancy = 1;
    - redirect overrides a simultaneous stall or flush.
  - flush: every stage = {RESET_PC, 0}; occupancy = 0.
  - stall: all stages and occupancy hold; pc_i/pc_valid_i are ignored and the fetch is lost. The upstream PC generator must hold pc_i during a stall.
  - shift: stage 0 = {pc_i, pc_valid_i}; stage k = stage k-1 for k ≥ 1; the old stage DEPTH-1 is discarded.
- Occupancy:
  - registered; always equals the popcount of stage_valid_o after each edge;
  - updated incrementally: +pc_valid_i −(old stage DEPTH-1 valid) on shift;
  - never exceeds DEPTH and never underflows.
- Latency: an un-stalled pc_i appears on pc_o exactly DEPTH cycles later. DEPTH=1 is cycle-equivalent to the previous single-register block.
- Invalid-stage PC values are don't-care for consumers, but are deterministic: they shift through like any other value.
- Only nonblocking assignments inside sequential logic.
- Width rule: redirect_pc and pc_i are full PC_W. There is no truncation or extension.

Decomposition:
- defines.vh: PC_WIDTH and PC_RESET_VAL, used as the defaults for PC_W and RESET_PC.
- One sub-module, pc_stage_reg:
  - one PC+valid register with async reset;
  - controls: load, clear, hold;
  - instantiated DEPTH times in a generate loop.
- The top level holds the priority decode, the stage chaining and the occupancy counter.

Test Plan:
- T1 Reset: rst pulsed mid-clock-period while stages are full → outputs go to PC=0, valid=0, occupancy=0 before the next edge. DEPTH=2, pc_i=0x100,0x104,0x108 all valid → pc_o=0x100 on cycle 2, 0x104 on cycle 3; occupancy goes 1, 2, 2.
- T2 Stall: pipeline full with 0x200/0x204, stall=1 for 3 cycles while pc_i changes → pc_o stays 0x200 and occupancy stays 2. Release stall → pc_o=0x204 on the next edge.
- T3 Redirect: pipeline full, redirect=1 with redirect_pc=0x400, stall=1 and flush=1 all in the same cycle → next cycle pc_o=0x400, pc_valid_o=1, stage 0 valid=0, occupancy=1.
- T4 Flush and work_ena: flush=1 → all valid=0, occupancy=0. Separately, work_ena=0 with redirect=1 → all clear (work_ena wins), pc_o=RESET_PC.
- T5 Bubbles: pc_valid_i pattern 1,0,1,0 → pc_valid_o reproduces 1,0,1,0 delayed by DEPTH cycles, and occupancy matches the popcount of stage_valid_o every cycle (scoreboard assertion).
- T6 Parameter sweep: repeat T1–T5 with DEPTH=1, 2, 5 and PC_W=16, 32 → latency = DEPTH and all taps are consistent with a reference shift model.
